llac_audio_core_router: RTL and testbench
=========================================

LLAC_AUDIO_CORE_ROUTER -- requirements
Module: llac_audio_core_router

Interface
REQ-001 Parameter NUM_CORES, default 4, number of audio cores/streams (>=2).
REQ-002 Parameter AUDIO_WIDTH, default 24, sample width per channel.
REQ-003 Parameter FIFO_DEPTH, default 8, output FIFO entries (power of two, >=2).
REQ-004 clk_100mhz  in  1  system clock; all logic in this domain.
REQ-005 resetn  in  1  reset, asynchronous, active-low.
REQ-006 in_left, in_right  in  AUDIO_WIDTH each  stereo sample.
REQ-007 in_chan  in  CID=$clog2(NUM_CORES)  target core of the sample.
REQ-008 in_valid  in  1  and  in_ready  out  1  input handshake.
REQ-009 out_left, out_right  out  AUDIO_WIDTH each  and  out_chan  out  CID.
REQ-010 out_valid  out  1  and  out_ready  in  1  output handshake.
REQ-011 core_pause, core_stop, core_resume, irq_clear  in  NUM_CORES each  one-cycle command pulses.
REQ-012 core_state  out  2*NUM_CORES  per-core FSM state, core i at bits [2i+1:2i].
REQ-013 core_irq  out  NUM_CORES  and  irq_out  out  1  interrupts.
REQ-014 drop_count  out  16*NUM_CORES  per-core dropped-sample counters.

Function
REQ-015 Each core SHALL have an FSM: IDLE(00), ACTIVE(01), PAUSED(10), STOPPED(11).
REQ-016 Transitions: IDLE->ACTIVE on resume; ACTIVE->PAUSED on pause; PAUSED->ACTIVE on resume; any non-STOPPED->STOPPED on stop; STOPPED->IDLE on irq_clear; no other transitions.
REQ-017 Simultaneous commands on one core SHALL resolve with priority stop > pause > resume; irq_clear is ignored outside STOPPED.
REQ-018 State changes SHALL take effect on the clock edge after the command; a sample accepted in the same cycle uses the pre-edge state.
REQ-019 A transfer occurs when in_valid && in_ready; in_ready SHALL be 1 iff the FIFO is not full. There is no same-cycle full bypass.
REQ-020 ACTIVE: the sample is pushed unchanged with out_chan=in_chan.
REQ-021 PAUSED: a zero-valued sample (left=right=0) is pushed with out_chan=in_chan, preserving stream timing.
REQ-022 IDLE or STOPPED: the sample is dropped, not pushed, and the input is still accepted.
REQ-023 in_chan >= NUM_CORES SHALL be treated as a drop that counts against no core.
REQ-024 out_valid SHALL be 1 iff the FIFO is non-empty. Output data is registered. Push-to-out_valid latency is 1 cycle.
REQ-025 Simultaneous push and pop SHALL be allowed at any occupancy except full, where push is blocked per REQ-019. Pointers wrap modulo FIFO_DEPTH.
REQ-026 Output data and out_chan SHALL hold stable while out_valid && !out_ready.
REQ-027 core_irq[i] SHALL set on entry to STOPPED and clear on the STOPPED->IDLE transition; irq_out SHALL be the OR of core_irq.

Reset
REQ-028 On resetn low, the following SHALL apply asynchronously: all FSMs=IDLE, FIFO empty, out_valid=0, out_left/out_right/out_chan=0, core_irq=0, irq_out=0, drop_count=0.
REQ-029 Reset mid-operation SHALL discard FIFO contents without emitting partial data.
REQ-030 in_ready SHALL be 0 while resetn is low and 1 from the first edge after release.

Configuration
REQ-031 Macro LLAC_ROUTER_DROP_CNT_EN defined: each core's drop_count SHALL increment by 1 per REQ-022 drop and saturate at 16'hFFFF; it is cleared only by reset.
REQ-032 Macro undefined: the counters SHALL NOT be built and drop_count SHALL be tied to 0.

Structure
REQ-033 Package llac_router_pkg SHALL hold the core_state_e enum with encodings as in REQ-015, the command priority constants, and the 16-bit counter width constant.
REQ-034 The FIFO SHALL be a sub-module llac_router_fifo, parametrised by width and depth, exposing full/empty flags.

Verification
REQ-035 Resume core 1, then send 0x123456/0x654321 on chan 1 -> out after 1 cycle with identical data and out_chan=1.
REQ-036 Pause core 2, then send 0x7FFFFF on chan 2 -> out emits 0/0 with out_chan=2; resume -> the next sample passes unchanged.
REQ-037 Hold out_ready=0 and push 8 samples with FIFO_DEPTH=8 -> in_ready=0 after the 8th; a 9th is held until out_ready=1 for one cycle.
REQ-038 Pulse stop and pause on core 0 in the same cycle -> state=STOPPED, core_irq[0]=1, irq_out=1; irq_clear[0] -> IDLE and irq=0.
REQ-039 With LLAC_ROUTER_DROP_CNT_EN defined, send 3 samples to IDLE core 3 -> drop_count[63:48]=3 and no output; without the macro -> drop_count=0.
REQ-040 Assert resetn=0 with 5 samples queued -> out_valid=0 immediately; after release, no stale data is emitted.

Source files
------------

// File: rtl/llac_router_pkg.sv
// Shared types and constants for the LLAC audio core router: per-core state
// encoding, command priority and drop-counter width.
package llac_router_pkg;

    localparam int CNT_W = 16;

    // Larger value wins when several commands hit one core in the same cycle.
    localparam logic [1:0] PRIO_STOP   = 2'd3;
    localparam logic [1:0] PRIO_PAUSE  = 2'd2;
    localparam logic [1:0] PRIO_RESUME = 2'd1;
    localparam logic [1:0] PRIO_NONE   = 2'd0;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_ACTIVE  = 2'b01,
        ST_PAUSED  = 2'b10,
        ST_STOPPED = 2'b11
    } core_state_e;

    typedef enum logic [1:0] {
        CMD_NONE   = PRIO_NONE,
        CMD_RESUME = PRIO_RESUME,
        CMD_PAUSE  = PRIO_PAUSE,
        CMD_STOP   = PRIO_STOP
    } core_cmd_e;

    function automatic core_cmd_e resolve_cmd(input logic stop,
                                              input logic pause,
                                              input logic resume);
        if (stop)
            return CMD_STOP;
        else if (pause)
            return CMD_PAUSE;
        else if (resume)
            return CMD_RESUME;
        else
            return CMD_NONE;
    endfunction

endpackage

// File: rtl/llac_router_fifo.sv
// Synchronous FIFO with registered storage, full/empty flags and async
// active-low reset that clears both pointers and storage.
module llac_router_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk_100mhz,
    input  logic             resetn,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_count == (AW+1)'(DEPTH));
    assign o_empty = (r_count == '0);
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_data  = r_mem[r_rd_ptr];

    always_ff @(posedge clk_100mhz or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < DEPTH; i++)
                r_mem[i] <= '0;
        end else if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointers are AW bits wide, so wrap modulo DEPTH comes for free.
    always_ff @(posedge clk_100mhz or negedge resetn) begin
        if (!resetn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push)
                r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/llac_audio_core_router.sv
// Routes stereo samples to per-core FSMs and queues them into an output FIFO.
// Optional per-core drop counters are built when LLAC_ROUTER_DROP_CNT_EN is defined.
//
//   state      | meaning
//   -----------+-------------------------------------------------
//   ST_IDLE    | core off, samples accepted and dropped
//   ST_ACTIVE  | samples forwarded unchanged
//   ST_PAUSED  | samples replaced by silence, timing preserved
//   ST_STOPPED | samples dropped, core_irq raised until irq_clear
module llac_audio_core_router
    import llac_router_pkg::*;
#(
    parameter int NUM_CORES   = 4,
    parameter int AUDIO_WIDTH = 24,
    parameter int FIFO_DEPTH  = 8,
    localparam int CID        = $clog2(NUM_CORES)
) (
    input  logic                       clk_100mhz,
    input  logic                       resetn,
    input  logic [AUDIO_WIDTH-1:0]     in_left,
    input  logic [AUDIO_WIDTH-1:0]     in_right,
    input  logic [CID-1:0]             in_chan,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic [AUDIO_WIDTH-1:0]     out_left,
    output logic [AUDIO_WIDTH-1:0]     out_right,
    output logic [CID-1:0]             out_chan,
    output logic                       out_valid,
    input  logic                       out_ready,
    input  logic [NUM_CORES-1:0]       core_pause,
    input  logic [NUM_CORES-1:0]       core_stop,
    input  logic [NUM_CORES-1:0]       core_resume,
    input  logic [NUM_CORES-1:0]       irq_clear,
    output logic [2*NUM_CORES-1:0]     core_state,
    output logic [NUM_CORES-1:0]       core_irq,
    output logic                       irq_out,
    output logic [CNT_W*NUM_CORES-1:0] drop_count
);

    localparam int DW = 2*AUDIO_WIDTH + CID;

    logic              r_rdy;
    logic              w_full;
    logic              w_empty;
    logic              w_xfer;
    logic              w_push;
    logic              w_pop;
    core_state_e       w_sel_state;
    logic [DW-1:0]     w_push_data;
    logic [DW-1:0]     w_pop_data;

    // in_ready stays low through reset and rises on the first edge after release.
    always_ff @(posedge clk_100mhz or negedge resetn) begin
        if (!resetn)
            r_rdy <= 1'b0;
        else
            r_rdy <= 1'b1;
    end

    assign in_ready = r_rdy && !w_full;
    assign w_xfer   = in_valid && in_ready;

    for (genvar g = 0; g < NUM_CORES; g++) begin : g_core
        core_state_e r_state;
        core_state_e w_state_nxt;
        core_cmd_e   w_cmd;
        logic        w_irq;

        assign w_cmd = resolve_cmd(core_stop[g], core_pause[g], core_resume[g]);

        always_ff @(posedge clk_100mhz or negedge resetn) begin
            if (!resetn)
                r_state <= ST_IDLE;
            else
                r_state <= w_state_nxt;
        end

        always_comb begin
            w_state_nxt = r_state;
            case (r_state)
                ST_IDLE: begin
                    if (w_cmd == CMD_STOP)
                        w_state_nxt = ST_STOPPED;
                    else if (w_cmd == CMD_RESUME)
                        w_state_nxt = ST_ACTIVE;
                end
                ST_ACTIVE: begin
                    if (w_cmd == CMD_STOP)
                        w_state_nxt = ST_STOPPED;
                    else if (w_cmd == CMD_PAUSE)
                        w_state_nxt = ST_PAUSED;
                end
                ST_PAUSED: begin
                    if (w_cmd == CMD_STOP)
                        w_state_nxt = ST_STOPPED;
                    else if (w_cmd == CMD_RESUME)
                        w_state_nxt = ST_ACTIVE;
                end
                ST_STOPPED: begin
                    if (irq_clear[g])
                        w_state_nxt = ST_IDLE;
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end

        always_comb begin
            w_irq = (r_state == ST_STOPPED);
        end

        assign core_state[2*g +: 2] = r_state;
        assign core_irq[g]          = w_irq;

`ifdef LLAC_ROUTER_DROP_CNT_EN
        logic             w_drop;
        logic [CNT_W-1:0] r_drop_cnt;

        assign w_drop = w_xfer && (in_chan == CID'(g)) &&
                        ((r_state == ST_IDLE) || (r_state == ST_STOPPED));

        always_ff @(posedge clk_100mhz or negedge resetn) begin
            if (!resetn)
                r_drop_cnt <= '0;
            else if (w_drop && (r_drop_cnt != {CNT_W{1'b1}}))
                r_drop_cnt <= r_drop_cnt + 1'b1;
        end

        assign drop_count[CNT_W*g +: CNT_W] = r_drop_cnt;
`endif
    end

`ifndef LLAC_ROUTER_DROP_CNT_EN
    assign drop_count = '0;
`endif

    assign irq_out = |core_irq;

    // An out-of-range channel matches no core and falls through as IDLE (drop).
    always_comb begin
        w_sel_state = ST_IDLE;
        for (int i = 0; i < NUM_CORES; i++) begin
            if (in_chan == CID'(i))
                w_sel_state = core_state_e'(core_state[2*i +: 2]);
        end
    end

    always_comb begin
        w_push      = 1'b0;
        w_push_data = {in_chan, in_left, in_right};
        if (w_xfer) begin
            if (w_sel_state == ST_ACTIVE) begin
                w_push = 1'b1;
            end else if (w_sel_state == ST_PAUSED) begin
                w_push      = 1'b1;
                w_push_data = {in_chan, {(2*AUDIO_WIDTH){1'b0}}};
            end
        end
    end

    assign w_pop = out_valid && out_ready;

    llac_router_fifo #(
        .WIDTH (DW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_100mhz (clk_100mhz),
        .resetn     (resetn),
        .i_push     (w_push),
        .i_data     (w_push_data),
        .i_pop      (w_pop),
        .o_data     (w_pop_data),
        .o_full     (w_full),
        .o_empty    (w_empty)
    );

    assign out_valid                        = !w_empty;
    assign {out_chan, out_left, out_right}  = w_pop_data;

endmodule

// File: tb/tb_llac_audio_core_router.sv
// Directed self-checking bench for llac_audio_core_router (default parameters).
module tb_llac_audio_core_router;

    logic        clk_100mhz = 1'b0;
    logic        resetn;
    logic [23:0] in_left, in_right;
    logic [1:0]  in_chan;
    logic        in_valid;
    logic        in_ready;
    logic [23:0] out_left, out_right;
    logic [1:0]  out_chan;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  core_pause, core_stop, core_resume, irq_clear;
    logic [7:0]  core_state;
    logic [3:0]  core_irq;
    logic        irq_out;
    logic [63:0] drop_count;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk_100mhz = ~clk_100mhz;

    llac_audio_core_router #(
        .NUM_CORES   (4),
        .AUDIO_WIDTH (24),
        .FIFO_DEPTH  (8)
    ) dut (
        .clk_100mhz  (clk_100mhz),
        .resetn      (resetn),
        .in_left     (in_left),
        .in_right    (in_right),
        .in_chan     (in_chan),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .out_left    (out_left),
        .out_right   (out_right),
        .out_chan    (out_chan),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .core_pause  (core_pause),
        .core_stop   (core_stop),
        .core_resume (core_resume),
        .irq_clear   (irq_clear),
        .core_state  (core_state),
        .core_irq    (core_irq),
        .irq_out     (irq_out),
        .drop_count  (drop_count)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_100mhz);
        #1;
    endtask

    task automatic send(input logic [1:0] ch, input logic [23:0] l, input logic [23:0] r);
        in_chan  = ch;
        in_left  = l;
        in_right = r;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        resetn      = 1'b0;
        in_left     = '0;
        in_right    = '0;
        in_chan     = '0;
        in_valid    = 1'b0;
        out_ready   = 1'b0;
        core_pause  = '0;
        core_stop   = '0;
        core_resume = '0;
        irq_clear   = '0;
        #2;
        check_eq("rst_state", core_state, 8'h00);
        check_eq("rst_out_valid", out_valid, 1'b0);
        check_eq("rst_in_ready", in_ready, 1'b0);
        check_eq("rst_irq", {core_irq, irq_out}, 5'h0);
        check_eq("rst_drop", drop_count, 64'h0);
        check_eq("rst_out_data", {out_chan, out_left, out_right}, 50'h0);
        tick();
        tick();
        resetn = 1'b1;
        check_eq("ready_before_edge", in_ready, 1'b0);
        tick();
        check_eq("ready_after_edge", in_ready, 1'b1);

        // Active passthrough on core 1
        out_ready      = 1'b1;
        core_resume[1] = 1'b1;
        tick();
        core_resume[1] = 1'b0;
        check_eq("c1_active", core_state[3:2], 2'b01);
        send(2'd1, 24'h123456, 24'h654321);
        check_eq("pass_valid", out_valid, 1'b1);
        check_eq("pass_data", {out_chan, out_left, out_right}, {2'd1, 24'h123456, 24'h654321});
        tick();
        check_eq("pass_popped", out_valid, 1'b0);

        // Pause core 2: zeros pushed, then passthrough after resume
        core_resume[2] = 1'b1;
        tick();
        core_resume[2] = 1'b0;
        core_pause[2]  = 1'b1;
        tick();
        core_pause[2]  = 1'b0;
        check_eq("c2_paused", core_state[5:4], 2'b10);
        send(2'd2, 24'h7FFFFF, 24'h7FFFFF);
        check_eq("pause_valid", out_valid, 1'b1);
        check_eq("pause_data", {out_chan, out_left, out_right}, {2'd2, 24'h0, 24'h0});
        core_resume[2] = 1'b1;
        tick();
        core_resume[2] = 1'b0;
        check_eq("c2_resumed", core_state[5:4], 2'b01);
        check_eq("pause_popped", out_valid, 1'b0);
        send(2'd2, 24'h0ABCDE, 24'h111111);
        check_eq("resume_data", {out_chan, out_left, out_right}, {2'd2, 24'h0ABCDE, 24'h111111});
        tick();

        // Fill FIFO with out_ready low
        out_ready = 1'b0;
        in_chan   = 2'd1;
        in_valid  = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            in_left  = 24'(k);
            in_right = 24'(k + 100);
            tick();
        end
        check_eq("full_ready", in_ready, 1'b0);
        check_eq("full_head", out_left, 24'd1);
        in_left  = 24'd9;
        in_right = 24'd109;
        tick();
        check_eq("full_hold_ready", in_ready, 1'b0);
        check_eq("full_hold_data", {out_chan, out_left, out_right}, {2'd1, 24'd1, 24'd101});
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check_eq("one_pop_ready", in_ready, 1'b1);
        check_eq("one_pop_head", out_left, 24'd2);
        tick();
        in_valid = 1'b0;
        check_eq("refull_ready", in_ready, 1'b0);
        out_ready = 1'b1;
        for (int k = 2; k <= 9; k++) begin
            check_eq("drain", {out_valid, out_left, out_right}, {1'b1, 24'(k), 24'(k + 100)});
            tick();
        end
        check_eq("drained", out_valid, 1'b0);

        // stop beats pause on core 0
        core_stop[0]  = 1'b1;
        core_pause[0] = 1'b1;
        tick();
        core_stop[0]  = 1'b0;
        core_pause[0] = 1'b0;
        check_eq("c0_stopped", core_state[1:0], 2'b11);
        check_eq("c0_irq", {core_irq[0], irq_out}, 2'b11);
        irq_clear[0] = 1'b1;
        tick();
        irq_clear[0] = 1'b0;
        check_eq("c0_idle", core_state[1:0], 2'b00);
        check_eq("c0_irq_clr", {core_irq[0], irq_out}, 2'b00);

        // pause beats resume on active core 1
        core_pause[1]  = 1'b1;
        core_resume[1] = 1'b1;
        tick();
        core_pause[1]  = 1'b0;
        core_resume[1] = 1'b0;
        check_eq("c1_prio_pause", core_state[3:2], 2'b10);

        // Drops to idle core 3
        for (int k = 0; k < 3; k++) begin
            check_eq("drop_ready", in_ready, 1'b1);
            send(2'd3, 24'hABCDEF, 24'h123123);
            check_eq("drop_no_out", out_valid, 1'b0);
        end
`ifdef LLAC_ROUTER_DROP_CNT_EN
        check_eq("drop_cnt3", drop_count, {16'd3, 48'h0});
`else
        check_eq("drop_cnt3", drop_count, 64'h0);
`endif

        // Reset with 5 samples queued
        core_resume[1] = 1'b1;
        tick();
        core_resume[1] = 1'b0;
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++)
            send(2'd1, 24'h500 + 24'(k), 24'h600);
        check_eq("queued_valid", out_valid, 1'b1);
        resetn = 1'b0;
        #1;
        check_eq("mid_rst_valid", out_valid, 1'b0);
        check_eq("mid_rst_ready", in_ready, 1'b0);
        check_eq("mid_rst_data", {out_chan, out_left, out_right}, 50'h0);
        check_eq("mid_rst_state", core_state, 8'h00);
        tick();
        resetn    = 1'b1;
        out_ready = 1'b1;
        tick();
        check_eq("post_rst_ready", in_ready, 1'b1);
        for (int k = 0; k < 3; k++) begin
            check_eq("post_rst_stale", out_valid, 1'b0);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
